uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
UART receive stage inside the SOC, fed directly by the RXD pin.
- Frame format: 8N1, LSB first, idle-high line.
- Synchronises the asynchronous line, validates the start bit, samples mid-bit and assembles the byte.
- Presents each byte to the CPU-side peripheral register through a one-entry valid/ready holding register, with sticky framing and overrun flags.

Parameters:
CLKS_PER_BIT, 215, clk cycles per bit (10 MHz clk, 21.5 us bit period); legal range 8..65535
SYNC_STAGES, 2, flip-flops in the RXD synchroniser; legal values 2..3

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  synchronous reset, active-low
rxd  input  1  asynchronous serial input, idle 1
rx_data  output  8  received byte; valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer pop; takes effect when rx_valid=1
busy  output  1  1 whenever the FSM is not in IDLE
framing_err  output  1  sticky: stop bit sampled 0
overrun_err  output  1  sticky: byte completed while holding register full and not popped
clr_err  input  1  clears both sticky flags
parity_err  output  1  sticky parity flag (present only with the optional feature)

Behaviour:
Reset:
- Applied when resetn=0 at a clk edge, including mid-frame.
- FSM goes to IDLE; counters clear.
- Synchroniser stages are set to 1.
- Outputs: rx_data=0x00, rx_valid=0, busy=0, framing_err=0, overrun_err=0, parity_err=0.
- Any partial frame is discarded.

Synchroniser:
- rxd passes through SYNC_STAGES flops to give rxd_s.
- Every timing point below refers to rxd_s.

FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: when rxd_s=0, go to START and load bit counter = CLKS_PER_BIT/2 - 1 (integer divide).
- START: count down to 0.
  - At 0, if rxd_s=0, go to DATA with counter = CLKS_PER_BIT-1 and bit index 0.
  - Otherwise treat it as a glitch: return to IDLE, with no flag and no data.
- DATA: at each counter 0, shift rxd_s into bit[index] (LSB first) and reload the counter.
  - After index 7, go to STOP, or to PARITY if the feature is enabled.
- STOP: at counter 0, sample rxd_s.
  - If 1, this is a good frame: next cycle rx_data = assembled byte and rx_valid = 1.
  - If 0, set framing_err, discard the byte, leave rx_valid unchanged.
  - Go to IDLE in the same cycle as the sample, i.e. mid-stop-bit. A start edge arriving at the nominal end of the stop bit is therefore caught.

Output handshake:
- A pop is rx_valid & rx_ready at a clk edge. It clears rx_valid next cycle; rx_data holds its last value.
- New byte while rx_valid=1 and no pop that cycle:
  - overrun_err is set.
  - The new byte is dropped; the old byte is kept.
- New byte in the same cycle as a pop:
  - The new byte is loaded.
  - rx_valid stays 1.
  - No overrun.

Error flags:
- clr_err clears framing_err, overrun_err and parity_err next cycle.
- If clr_err coincides with a new error event, the set wins.

Latency:
- Good frame: rx_valid rises 1 cycle after the stop-bit sample.
- The stop-bit sample occurs SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the rxd falling edge.
- Up to approximately 45% bit-period skew per frame is tolerated.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - A PARITY state is inserted after DATA, lasting one CLKS_PER_BIT.
  - The parity bit is sampled mid-bit; the check is even parity.
  - On mismatch: set sticky parity_err and discard the byte; rx_valid is not set. The FSM still proceeds through STOP.
  - The parity_err port exists.
- Undefined: no PARITY state and no parity_err port; behaviour is exactly 8N1.

Test Plan:
- Reset, then send 0x35 at 21500 ns/bit with rx_ready=0 → rx_valid=1, rx_data=0x35, busy=0 after the stop sample, no flags set.
- With rx_ready held 1, send 0x37, 0x38, 0x0D back-to-back → three pops with data 0x37, 0x38, 0x0D in order; overrun_err=0.
- Send 0x31, then 0x34, with rx_ready=0 → rx_data stays 0x31, overrun_err=1. Then clr_err → overrun_err=0. Then pop → rx_valid=0.
- Hold rxd low for 50 cycles, then return high → FSM returns to IDLE, rx_valid=0, no flags set. Next send 0x0D → received correctly.
- Send 0xA5 with the stop bit driven 0 → framing_err=1, rx_valid stays 0, rx_data unchanged. Next good byte 0x5A is received.
- Pull resetn low at bit index 4 of 0xFF, release, then send 0x00 → only 0x00 is delivered, with no error flags. With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 → parity_err=1 and no rx_valid.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: RXD synchroniser, mid-bit sampling FSM and a one-entry valid/ready holding register.
// Optional even-parity bit and parity_err port when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 215,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun_err,
  input  logic       clr_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   oe_q, oe_d;
  logic                   rxd_s, pop, byte_done, stop_bad, par_fail;
`ifdef UART_RX_PARITY_EN
  logic                   pe_q, pe_d;
  logic                   par_bad_q, par_bad_d;
  logic                   par_set;
  assign par_fail   = par_bad_q;
  assign parity_err = pe_q;
`else
  assign par_fail   = 1'b0;
`endif

  assign sync_d      = {sync_q[SYNC_STAGES-2:0], rxd};
  assign rxd_s       = sync_q[SYNC_STAGES-1];
  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = fe_q;
  assign overrun_err = oe_q;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q      <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
`ifdef UART_RX_PARITY_EN
      pe_q      <= pe_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rxd_s) state_d = START;
      START:  if (cnt_q == '0) state_d = rxd_s ? IDLE : DATA;
      DATA:   if (cnt_q == '0 && idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
        state_d = PARITY;
`else
        state_d = STOP;
`endif
      end
      PARITY: if (cnt_q == '0) state_d = STOP;
      STOP:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Preload half a bit so START lands in the middle of the start bit.
        cnt_d = HALF;
        idx_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      START: cnt_d = (cnt_q == '0) ? FULL : cnt_q - 16'd1;
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxd_s;
          idx_d          = idx_q + 3'd1;
          cnt_d          = FULL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          par_bad_d = ^{shift_q, rxd_s};
          par_set   = ^{shift_q, rxd_s};
          cnt_d     = FULL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          byte_done = rxd_s & ~par_fail;
          stop_bad  = ~rxd_s;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: ;
    endcase

    pop     = valid_q & rx_ready;
    data_d  = data_q;
    valid_d = valid_q & ~pop;
    fe_d    = fe_q & ~clr_err;
    oe_d    = oe_q & ~clr_err;
    // A new byte landing on a pop replaces the popped one without overrun.
    if (byte_done) begin
      if (valid_q & ~pop) begin
        oe_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
    if (stop_bad) fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    pe_d = (pe_q & ~clr_err) | par_set;
`endif
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: table of frame/pop/clear/glitch steps plus hand-written corner sequences.
module tb_uart_rx_byte;
  localparam int CPB = 215;
  localparam int OP_FRAME = 0, OP_POP = 1, OP_CLR = 2, OP_GLITCH = 3;
  localparam int NV = 13;

  typedef struct {
    int         op;
    logic [7:0] din;
    logic       stop;
    logic       ev;
    logic [7:0] ed;
    logic       efe;
    logic       eoe;
  } vec_t;

  logic       clk = 1'b0, resetn = 1'b0, rxd = 1'b1, rx_ready = 1'b0, clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, busy, framing_err, overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_force = 1'b0;
`endif

  int         total = 0, bad = 0;
  logic       mon_en = 1'b0;
  logic [7:0] popq[$];
  vec_t       tbl[NV];

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .framing_err(framing_err), .overrun_err(overrun_err),
    .clr_err(clr_err)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #50 clk = ~clk;

  always @(negedge clk) if (mon_en && rx_valid && rx_ready) popq.push_back(rx_data);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop bit level is held for 3/5 of a bit, then the line idles high.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0; wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; wait_clks(CPB); end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_force; wait_clks(CPB);
`endif
    rxd = stop; wait_clks(CPB * 3 / 5);
    rxd = 1'b1; wait_clks(CPB - CPB * 3 / 5);
  endtask

  task automatic chk_state(input string nm, input logic ev, input logic [7:0] ed,
                           input logic efe, input logic eoe, input logic ebusy);
    chk({nm, ".valid"}, {7'b0, rx_valid}, {7'b0, ev});
    chk({nm, ".data"}, rx_data, ed);
    chk({nm, ".ferr"}, {7'b0, framing_err}, {7'b0, efe});
    chk({nm, ".oerr"}, {7'b0, overrun_err}, {7'b0, eoe});
    chk({nm, ".busy"}, {7'b0, busy}, {7'b0, ebusy});
  endtask

  initial begin
    tbl[0]  = '{OP_FRAME,  8'h35, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0};
    tbl[1]  = '{OP_POP,    8'h00, 1'b1, 1'b0, 8'h35, 1'b0, 1'b0};
    tbl[2]  = '{OP_FRAME,  8'h31, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
    tbl[3]  = '{OP_FRAME,  8'h34, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1};
    tbl[4]  = '{OP_CLR,    8'h00, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
    tbl[5]  = '{OP_POP,    8'h00, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
    tbl[6]  = '{OP_GLITCH, 8'h00, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
    tbl[7]  = '{OP_FRAME,  8'h0D, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0};
    tbl[8]  = '{OP_POP,    8'h00, 1'b1, 1'b0, 8'h0D, 1'b0, 1'b0};
    tbl[9]  = '{OP_FRAME,  8'hA5, 1'b0, 1'b0, 8'h0D, 1'b1, 1'b0};
    tbl[10] = '{OP_CLR,    8'h00, 1'b1, 1'b0, 8'h0D, 1'b0, 1'b0};
    tbl[11] = '{OP_FRAME,  8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[12] = '{OP_POP,    8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};

    wait_clks(5);
    chk_state("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk("reset.perr", {7'b0, parity_err}, 8'h00);
`endif
    resetn = 1'b1;
    wait_clks(5);
    chk_state("post_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      case (tbl[i].op)
        OP_FRAME:  begin send_frame(tbl[i].din, tbl[i].stop); wait_clks(CPB / 2 + 20); end
        OP_POP:    begin rx_ready = 1'b1; wait_clks(1); rx_ready = 1'b0; wait_clks(2); end
        OP_CLR:    begin clr_err = 1'b1; wait_clks(1); clr_err = 1'b0; wait_clks(2); end
        default:   begin rxd = 1'b0; wait_clks(50); rxd = 1'b1; wait_clks(CPB); end
      endcase
      chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].efe, tbl[i].eoe, 1'b0);
    end

    // Back-to-back frames with the consumer always ready.
    mon_en = 1'b1; rx_ready = 1'b1;
    send_frame(8'h37, 1'b1);
    send_frame(8'h38, 1'b1);
    send_frame(8'h0D, 1'b1);
    wait_clks(CPB);
    mon_en = 1'b0; rx_ready = 1'b0;
    chk("b2b.count", 8'(popq.size()), 8'd3);
    if (popq.size() == 3) begin
      chk("b2b.pop0", popq[0], 8'h37);
      chk("b2b.pop1", popq[1], 8'h38);
      chk("b2b.pop2", popq[2], 8'h0D);
    end
    chk_state("b2b", 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of bit 4 of 0xFF.
    rxd = 1'b0; wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin rxd = 1'b1; wait_clks(CPB); end
    wait_clks(CPB / 2);
    chk("midframe.busy", {7'b0, busy}, 8'h01);
    resetn = 1'b0; wait_clks(3);
    chk_state("midframe_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    wait_clks(5 * CPB);
    chk_state("after_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1);
    wait_clks(CPB / 2 + 20);
    chk_state("zero_byte", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    rx_ready = 1'b1; wait_clks(1); rx_ready = 1'b0; wait_clks(2);
    par_force = 1'b1;
    send_frame(8'h07, 1'b1);
    par_force = 1'b0;
    wait_clks(CPB / 2 + 20);
    chk_state("parity_bad", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("parity_bad.perr", {7'b0, parity_err}, 8'h01);
    clr_err = 1'b1; wait_clks(1); clr_err = 1'b0; wait_clks(2);
    chk("parity_clr.perr", {7'b0, parity_err}, 8'h00);
    send_frame(8'h07, 1'b1);
    wait_clks(CPB / 2 + 20);
    chk_state("parity_good", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
